ldo_power_sequencer: RTL
========================

// Module: ldo_power_sequencer
// PURPOSE
//  Wishbone-programmable power sequencer for the EF_LDOR1V8E regulator bank in user_project_wrapper.
//  - Power-up: drives the LDO enables in ascending index order, with programmable inter-stage delays.
//  - Power-down: removes the enables in descending index order.
//  - Monitors per-LDO power-good and forces a safe all-off state on timeout or dropout.
//  - Sits between the Caravel Wishbone slave port and the LDO en pins (routed via analog_io).
// PARAMETERS
//  N_LDO     3       number of sequenced regulators (1..8)
//  CNT_W     16      width of delay/timeout counters
//  DLY_RST   16'd100 reset value of DLY_UP and DLY_DN (cycles)
//  TMO_RST   16'd1000 reset value of PG_TIMEOUT (cycles)
// PORTS
//  wb_clk_i    in   1      sole clock
//  wb_rst_ni   in   1      asynchronous reset, active-low
//  wbs_cyc_i   in   1      Wishbone cycle
//  wbs_stb_i   in   1      Wishbone strobe
//  wbs_we_i    in   1      Wishbone write enable
//  wbs_sel_i   in   4      byte selects; writes honour these per byte
//  wbs_adr_i   in   32     byte address; decode uses [4:2]
//  wbs_dat_i   in   32     write data
//  wbs_dat_o   out  32     read data
//  wbs_ack_o   out  1      single-cycle acknowledge
//  ldo_pg_i    in   N_LDO  asynchronous power-good, one per LDO; 2-FF synchronised internally
//  ldo_en_o    out  N_LDO  registered LDO enables
//  seq_done_o  out  1      high while in ON
//  fault_irq_o out  1      high while in FAULT (routes to user_irq[0])
// BEHAVIOUR
//  Reset values: all outputs 0, state IDLE, registers at their defaults.
//  Wishbone:
//   - ack rises one cycle after cyc&stb while ack is low, then drops the next cycle.
//   - Register side effects commit on the ack cycle.
//   - Unmapped reads return 0; unmapped writes are ignored.
//  Register map:
//   0x00 CTRL   W: b0 START, b1 STOP, b2 CLR_FAULT. Strobes; reads return 0.
//   0x04 STATUS R: [2:0] state, [15:8] ldo_en_o, [23:16] pg_sync, [31] fault.
//   0x08 DLY_UP, 0x0C DLY_DN, 0x10 PG_TIMEOUT   RW [CNT_W-1:0]; a value of 0 acts as 1.
//  FSM states: IDLE=0, UP=1, ON=2, DOWN=3, FAULT=4. idx is the current LDO index.
//   IDLE -START-> UP, idx=0.
//    - ldo_en_o[0] is 1 on the cycle after the START ack.
//    - Delay counter loads DLY_UP; timeout counter loads PG_TIMEOUT.
//   UP: a stage completes when the delay counter reaches 0 AND pg_sync[idx]=1.
//    - On completion, idx++ and the next enable is set on the following cycle.
//    - After stage N_LDO-1 completes -> ON.
//    - Timeout counter reaches 0 before pg_sync[idx] -> FAULT.
//   ON: any pg_sync bit of an enabled LDO falls -> FAULT.
//   UP/ON -STOP-> DOWN.
//    - The highest enabled LDO is cleared first.
//    - Each subsequent clear follows DLY_DN cycles later.
//    - Once all enables are 0 -> IDLE.
//   FAULT:
//    - ldo_en_o = 0 on the very next cycle.
//    - fault_irq_o = 1 until CLR_FAULT, which returns to IDLE.
//  Conflicts and ignored commands:
//   - START and STOP written together: STOP wins.
//   - START outside IDLE is ignored.
//   - STOP in IDLE or FAULT is ignored.
//   - CLR_FAULT outside FAULT is ignored.
//   - A pg drop during DOWN is ignored.
//  Delay-register writes take effect at the next counter load, never mid-count.
//  Asserting reset at any point clears ldo_en_o asynchronously.
// CONFIGURATION
//  LDO_SEQ_PG_EN defined:
//   - ldo_pg_i, the 2-FF synchronisers, PG_TIMEOUT and both fault paths are present.
//  LDO_SEQ_PG_EN undefined:
//   - Pure timed sequencing: stages complete on the delay counter alone.
//   - pg_sync reads as all-ones; PG_TIMEOUT reads 0 and is not writable.
//   - FAULT is unreachable; fault_irq_o is tied to 0.
// STRUCTURE
//  Package ldo_seq_pkg:
//   - seq_state_t enum (IDLE..FAULT).
//   - Register offsets ADR_CTRL..ADR_TMO and CTRL bit indices.
//  Sub-module ldo_seq_timer: loadable down-counter (CNT_W wide) with load and zero flag.
//   - Instantiated twice: stage delay and pg timeout.
// TESTING
//  1. Reset, read STATUS -> 0; read DLY_UP -> 100.
//  2. DLY_UP=4, pg follows en after 2 cycles, START.
//     - en goes 001 -> 011 -> 111 with 4-cycle spacing.
//     - seq_done_o=1; STATUS[2:0]=2.
//  3. From ON, DLY_DN=3, STOP -> en goes 111 -> 011 -> 001 -> 000, 3 cycles apart; state IDLE.
//  4. PG_EN defined, PG_TIMEOUT=10, pg[1] held at 0 -> FAULT ~10 cycles after en[1]=1.
//     - en=000, fault_irq_o=1.
//     - CLR_FAULT -> IDLE, irq=0.
//  5. In ON, drop pg[2] -> en=000 next cycle after the sync delay; STATUS[31]=1.
//  6. Write CTRL=0x3 in IDLE -> stays IDLE.
//     - START mid-UP ignored; wb_rst_ni low mid-UP -> en=000 immediately.

Source files
------------

// File: rtl/ldo_seq_pkg.sv
// ldo_seq_pkg: state encoding, register map, CTRL bit indices and byte-select write merge
// shared by ldo_power_sequencer and its timer.
package ldo_seq_pkg;
  typedef enum logic [2:0] {IDLE = 3'd0, UP = 3'd1, ON = 3'd2, DOWN = 3'd3, FAULT = 3'd4} seq_state_t;
  localparam logic [2:0] ADR_CTRL = 3'd0, ADR_STAT = 3'd1, ADR_DUP = 3'd2, ADR_DDN = 3'd3, ADR_TMO = 3'd4;
  localparam int CTRL_START = 0, CTRL_STOP = 1, CTRL_CLR = 2;
  function automatic logic [31:0] wmerge(input logic [31:0] old, input logic [31:0] dat, input logic [3:0] sel);
    logic [31:0] m;
    m = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    return (old & ~m) | (dat & m);
  endfunction
endpackage

// File: rtl/ldo_seq_timer.sv
// ldo_seq_timer: loadable down-counter; loading v raises zero v cycles later (0 behaves as 1).
module ldo_seq_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] val,
  output logic             zero
);
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (load) cnt <= (val == '0) ? '0 : val - CNT_W'(1);
    else if (cnt != '0) cnt <= cnt - CNT_W'(1);
  assign zero = (cnt == '0);
endmodule

// File: rtl/ldo_power_sequencer.sv
// ldo_power_sequencer: Wishbone-programmed up/down sequencing of an LDO bank.
// Define LDO_SEQ_PG_EN to add power-good synchronisers, the pg timeout and both fault paths.
module ldo_power_sequencer
  import ldo_seq_pkg::*;
#(
  parameter int N_LDO   = 3,
  parameter int CNT_W   = 16,
  parameter int DLY_RST = 100,
  parameter int TMO_RST = 1000
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_ni,
  input  logic             wbs_cyc_i,
  input  logic             wbs_stb_i,
  input  logic             wbs_we_i,
  input  logic [3:0]       wbs_sel_i,
  input  logic [31:0]      wbs_adr_i,
  input  logic [31:0]      wbs_dat_i,
  output logic [31:0]      wbs_dat_o,
  output logic             wbs_ack_o,
  input  logic [N_LDO-1:0] ldo_pg_i,
  output logic [N_LDO-1:0] ldo_en_o,
  output logic             seq_done_o,
  output logic             fault_irq_o
);
  localparam logic [N_LDO-1:0] ONE = N_LDO'(1);
  seq_state_t state, state_nxt;
  logic [N_LDO-1:0] en_nxt, pg_sync;
  logic [CNT_W-1:0] dly_up, dly_dn, dly_val;
  logic [31:0] tmo_rd, stat;
  logic [7:0] en8, pg8;
  logic [2:0] adr;
  logic wr, ctrl_wr, start, stop, clr, dly_load, dly_zero, stage_pg, fault_det, unused;
  assign adr     = wbs_adr_i[4:2];
  assign wr      = wbs_ack_o & wbs_cyc_i & wbs_stb_i & wbs_we_i;
  assign ctrl_wr = wr & (adr == ADR_CTRL) & wbs_sel_i[0];
  assign start   = ctrl_wr & wbs_dat_i[CTRL_START];
  assign stop    = ctrl_wr & wbs_dat_i[CTRL_STOP];
  assign clr     = ctrl_wr & wbs_dat_i[CTRL_CLR];
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni)
    if (!wb_rst_ni) wbs_ack_o <= 1'b0;
    else wbs_ack_o <= wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni)
    if (!wb_rst_ni) begin
      dly_up <= CNT_W'(DLY_RST);
      dly_dn <= CNT_W'(DLY_RST);
    end else if (wr) begin
      if (adr == ADR_DUP) dly_up <= CNT_W'(wmerge(32'(dly_up), wbs_dat_i, wbs_sel_i));
      if (adr == ADR_DDN) dly_dn <= CNT_W'(wmerge(32'(dly_dn), wbs_dat_i, wbs_sel_i));
    end
  ldo_seq_timer #(.CNT_W(CNT_W)) u_dly (
    .clk(wb_clk_i), .rst_n(wb_rst_ni), .load(dly_load), .val(dly_val), .zero(dly_zero)
  );
`ifdef LDO_SEQ_PG_EN
  logic [CNT_W-1:0] tmo;
  logic [N_LDO-1:0] pg_meta;
  logic tmo_load, tmo_zero;
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni)
    if (!wb_rst_ni) tmo <= CNT_W'(TMO_RST);
    else if (wr && adr == ADR_TMO) tmo <= CNT_W'(wmerge(32'(tmo), wbs_dat_i, wbs_sel_i));
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni)
    if (!wb_rst_ni) {pg_sync, pg_meta} <= '0;
    else {pg_sync, pg_meta} <= {pg_meta, ldo_pg_i};
  // every stage start in UP restarts the pg watchdog alongside the stage delay
  assign tmo_load = dly_load & (state_nxt == UP);
  ldo_seq_timer #(.CNT_W(CNT_W)) u_tmo (
    .clk(wb_clk_i), .rst_n(wb_rst_ni), .load(tmo_load), .val(tmo), .zero(tmo_zero)
  );
  assign fault_det   = (state == UP && tmo_zero && !stage_pg) || (state == ON && |(ldo_en_o & ~pg_sync));
  assign tmo_rd      = 32'(tmo);
  assign fault_irq_o = (state == FAULT);
  assign unused      = ^{wbs_adr_i[31:5], wbs_adr_i[1:0]};
`else
  assign pg_sync     = '1;
  assign fault_det   = 1'b0;
  assign tmo_rd      = '0;
  assign fault_irq_o = 1'b0;
  assign unused      = ^{wbs_adr_i[31:5], wbs_adr_i[1:0], ldo_pg_i};
`endif
  // enables are always a thermometer code, so the top set bit is the active stage
  assign stage_pg = |(pg_sync & ldo_en_o & ~(ldo_en_o >> 1));
  always_comb begin
    state_nxt = state;
    en_nxt    = ldo_en_o;
    dly_load  = 1'b0;
    dly_val   = dly_dn;
    if (state == IDLE && start && !stop) begin
      state_nxt = UP;
      en_nxt    = ONE;
      dly_load  = 1'b1;
      dly_val   = dly_up;
    end else if ((state == DOWN && dly_zero) || ((state == UP || state == ON) && stop)) begin
      en_nxt    = ldo_en_o >> 1;
      dly_load  = 1'b1;
      state_nxt = (en_nxt == '0) ? IDLE : DOWN;
    end else if (state == UP && dly_zero && stage_pg) begin
      state_nxt = ldo_en_o[N_LDO-1] ? ON : UP;
      en_nxt    = (ldo_en_o << 1) | ONE;
      dly_load  = !ldo_en_o[N_LDO-1];
      dly_val   = dly_up;
    end else if (state == FAULT && clr) begin
      state_nxt = IDLE;
    end
    if (fault_det) begin
      state_nxt = FAULT;
      en_nxt    = '0;
    end
  end
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni)
    if (!wb_rst_ni) begin
      state    <= IDLE;
      ldo_en_o <= '0;
    end else begin
      state    <= state_nxt;
      ldo_en_o <= en_nxt;
    end
  assign seq_done_o = (state == ON);
  assign en8        = 8'(ldo_en_o);
  assign pg8        = 8'(pg_sync);
  assign stat       = {state == FAULT, 7'd0, pg8, en8, 5'd0, state};
  assign wbs_dat_o  = (adr == ADR_STAT) ? stat :
                      (adr == ADR_DUP)  ? 32'(dly_up) :
                      (adr == ADR_DDN)  ? 32'(dly_dn) :
                      (adr == ADR_TMO)  ? tmo_rd : '0;
endmodule
